delay_addr_ctrl: RTL and testbench

//   Address/strobe generator directly upstream of the dual-port sample RAM in the

---
 rtl/delay_addr_ctrl.sv | 130 +++++++++++++
 tb/tb_delay_addr_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_addr_ctrl.sv
// Write/read address and strobe generator for the delay-line sample RAM.
// Samples are paced by a divider; reads trail writes by a programmable delay.
module delay_addr_ctrl #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DIV_WIDTH     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  logic [DIV_WIDTH-1:0]     div_i,
    input  logic [ADDRESS_WIDTH-1:0] delay_i,
    output logic                     wen_o,
    output logic [ADDRESS_WIDTH-1:0] wad_o,
    output logic                     ren_o,
    output logic [ADDRESS_WIDTH-1:0] rad_o,
    output logic                     rd_valid_o,
    output logic                     primed_o
);

    // state | meaning
    // IDLE  | disabled, no strobes
    // PRIME | writing, waiting for the buffer to hold eff_dly fresh samples
    // RUN   | writing and reading on every tick
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [DIV_WIDTH-1:0]     tick_cnt_q, tick_cnt_d;
    logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDRESS_WIDTH:0]   fill_q, fill_d;
    logic [ADDRESS_WIDTH-1:0] dly_q, dly_d;
    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] wad_q, wad_d;
    logic                     ren_q, ren_d;
    logic [ADDRESS_WIDTH-1:0] rad_q, rad_d;
    logic                     rd_valid_q, rd_valid_d;

    logic                     tick;
    logic [ADDRESS_WIDTH:0]   eff_dly;
    logic [ADDRESS_WIDTH:0]   fill_inc;

    always_comb begin
        tick       = en_i && (tick_cnt_q == div_i);
        // A programmed delay of zero stands for the full buffer depth.
        eff_dly    = {(dly_q == '0), dly_q};
        fill_inc   = fill_q + 1'b1;

        state_d    = state_q;
        wptr_d     = wptr_q;
        fill_d     = fill_q;
        dly_d      = dly_q;
        wen_d      = 1'b0;
        wad_d      = wad_q;
        ren_d      = 1'b0;
        rad_d      = rad_q;
        rd_valid_d = ren_q;

        if (!en_i)
            tick_cnt_d = '0;
        else if (tick)
            tick_cnt_d = '0;
        else
            tick_cnt_d = tick_cnt_q + 1'b1;

        if (!en_i) begin
            state_d = ST_IDLE;
            fill_d  = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_PRIME;
            dly_d   = delay_i;
            fill_d  = '0;
        end else begin
            if (tick) begin
                wen_d  = 1'b1;
                wad_d  = wptr_q;
                wptr_d = wptr_q + 1'b1;
            end
            if (delay_i != dly_q) begin
                dly_d   = delay_i;
                fill_d  = '0;
                state_d = ST_PRIME;
            end else if (tick) begin
                if (state_q == ST_RUN) begin
                    ren_d = 1'b1;
                    // Full-depth delay wraps to rad == wad (read-before-write).
                    rad_d = wptr_q - dly_q;
                end else begin
                    fill_d = fill_inc;
                    if (fill_inc == eff_dly)
                        state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            wptr_q     <= '0;
            fill_q     <= '0;
            dly_q      <= '0;
            wen_q      <= 1'b0;
            wad_q      <= '0;
            ren_q      <= 1'b0;
            rad_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            wptr_q     <= wptr_d;
            fill_q     <= fill_d;
            dly_q      <= dly_d;
            wen_q      <= wen_d;
            wad_q      <= wad_d;
            ren_q      <= ren_d;
            rad_q      <= rad_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign wen_o      = wen_q;
    assign wad_o      = wad_q;
    assign ren_o      = ren_q;
    assign rad_o      = rad_q;
    assign rd_valid_o = rd_valid_q;
    assign primed_o   = (state_q == ST_RUN);

endmodule

// File: tb/tb_delay_addr_ctrl.sv
// Bench for delay_addr_ctrl: cycle model feeds an expected-output queue that is
// checked every clock, plus scenario tasks with fixed expected values.
module tb_delay_addr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div = '0;
    logic [8:0]  delay = '0;
    logic        wen, ren, rd_valid, primed;
    logic [8:0]  wad, rad;

    int total = 0;
    int bad = 0;

    logic [21:0] exp_q[$];

    int m_st, m_cnt, m_wptr, m_fill, m_dly;
    int m_wen, m_wad, m_ren, m_rad, m_rdv;

    delay_addr_ctrl #(.ADDRESS_WIDTH(9), .DIV_WIDTH(16)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .div_i      (div),
        .delay_i    (delay),
        .wen_o      (wen),
        .wad_o      (wad),
        .ren_o      (ren),
        .rad_o      (rad),
        .rd_valid_o (rd_valid),
        .primed_o   (primed)
    );

    always #5 clk = ~clk;

    task automatic model_write();
        m_wen  = 1;
        m_wad  = m_wptr;
        m_wptr = (m_wptr + 1) % 512;
    endtask

    // Advance the reference model one clock, then the DUT, then compare.
    task automatic step();
        int tick, eff;
        logic [21:0] e, a;
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_wptr = 0; m_fill = 0; m_dly = 0;
            m_wen = 0; m_wad = 0; m_ren = 0; m_rad = 0; m_rdv = 0;
        end else begin
            tick  = (en && (m_cnt == int'(div))) ? 1 : 0;
            m_rdv = m_ren;
            m_wen = 0;
            m_ren = 0;
            m_cnt = (!en || tick != 0) ? 0 : (m_cnt + 1) % 65536;
            eff   = (m_dly == 0) ? 512 : m_dly;
            if (!en) begin
                m_st = 0; m_fill = 0;
            end else if (m_st == 0) begin
                m_st = 1; m_dly = int'(delay); m_fill = 0;
            end else if (int'(delay) != m_dly) begin
                if (tick != 0) model_write();
                m_dly = int'(delay); m_fill = 0; m_st = 1;
            end else if (tick != 0) begin
                if (m_st == 2) begin
                    m_ren = 1;
                    m_rad = (m_wptr - eff + 512) % 512;
                end else begin
                    m_fill++;
                    if (m_fill == eff) m_st = 2;
                end
                model_write();
            end
        end
        e = {m_wen != 0, 9'(m_wad), m_ren != 0, 9'(m_rad), m_rdv != 0, m_st == 2};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a = {wen, wad, ren, rad, rd_valid, primed};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                bad++;
                $display("FAIL outputs t=%0t actual=%h expected=%h (wen,wad,ren,rad,rdv,primed)",
                         $time, a, e);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; div = 16'd3; delay = 9'd4;
        step();
        step();
        total++;
        if ({wen, wad, ren, rad, rd_valid, primed} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs actual=%h expected=0",
                     {wen, wad, ren, rad, rd_valid, primed});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int  nwr = 0;
        bit  seen_ren = 0, seen_pr = 0, chk_rdv = 0;
        do_reset();
        div = 16'd3; delay = 9'd4; en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (chk_rdv) begin
                chk_rdv = 0;
                total++;
                if (rd_valid !== 1'b1) begin
                    bad++; $display("FAIL basic_rd_valid actual=%b expected=1", rd_valid);
                end
            end
            if (ren && !seen_ren) begin
                seen_ren = 1; chk_rdv = 1;
                total++;
                if (wad !== 9'd4 || rad !== 9'd0) begin
                    bad++; $display("FAIL basic_first_read wad=%0d rad=%0d expected wad=4 rad=0", wad, rad);
                end
            end
            if (wen) begin
                total++;
                if (wad !== 9'(nwr)) begin
                    bad++; $display("FAIL basic_wad actual=%0d expected=%0d", wad, nwr);
                end
                nwr++;
            end
            if (primed && !seen_pr) begin
                seen_pr = 1;
                total++;
                if (nwr != 4) begin
                    bad++; $display("FAIL basic_primed_at_write actual=%0d expected=4", nwr);
                end
            end
        end
        total++;
        if (!seen_ren || !seen_pr) begin
            bad++; $display("FAIL basic_timeout ren_seen=%0d primed_seen=%0d expected 1 1", seen_ren, seen_pr);
        end
    endtask

    task automatic test_full_depth();
        int nwr = 0;
        bit done = 0;
        do_reset();
        div = 16'd0; delay = 9'd0; en = 1'b1;
        for (int i = 0; i < 700; i++) begin
            step();
            if (ren) begin
                done = 1;
                total++;
                if (nwr != 512 || rad !== wad || wad !== 9'd0) begin
                    bad++; $display("FAIL full_depth writes=%0d wad=%0d rad=%0d expected 512 0 0", nwr, wad, rad);
                end
                break;
            end
            if (wen) nwr++;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL full_depth_timeout actual=no_read expected=read");
        end
    endtask

    task automatic test_wrap();
        int nwr = 0;
        bit done = 0;
        do_reset();
        div = 16'd0; delay = 9'd3; en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (wen) begin
                nwr++;
                if (nwr == 513) begin
                    total++;
                    if (wad !== 9'd0) begin
                        bad++; $display("FAIL wrap_wad actual=%0d expected=0", wad);
                    end
                end
                if (nwr == 514) begin
                    done = 1;
                    total++;
                    if (wad !== 9'd1 || ren !== 1'b1 || rad !== 9'd510) begin
                        bad++; $display("FAIL wrap_rad wad=%0d ren=%b rad=%0d expected 1 1 510", wad, ren, rad);
                    end
                    break;
                end
            end
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL wrap_timeout writes=%0d expected=514", nwr);
        end
    endtask

    task automatic test_delay_change();
        int wonly = 0;
        bit done = 0;
        logic [8:0] exp_rad;
        do_reset();
        div = 16'd1; delay = 9'd4; en = 1'b1;
        for (int i = 0; i < 100 && !(wen && ren); i++) step();
        total++;
        if (!(wen && ren)) begin
            bad++; $display("FAIL chg_reach_run actual=not_run expected=run");
        end
        delay = 9'd2;
        step();
        total++;
        if (primed !== 1'b0 || ren !== 1'b0) begin
            bad++; $display("FAIL chg_primed_drop primed=%b ren=%b expected 0 0", primed, ren);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (ren) begin
                done = 1;
                exp_rad = wad - 9'd2;
                total++;
                if (wonly != 2 || rad !== exp_rad || wen !== 1'b1) begin
                    bad++; $display("FAIL chg_resume writes=%0d rad=%0d expected 2 %0d", wonly, rad, exp_rad);
                end
                break;
            end
            if (wen) wonly++;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL chg_timeout actual=no_read expected=read");
        end
    endtask

    task automatic test_en_drop();
        int nw = 0, strobes = 0;
        bit done = 0;
        logic [8:0] last_wad = '0;
        do_reset();
        div = 16'd1; delay = 9'd4; en = 1'b1;
        for (int i = 0; i < 20 && nw < 2; i++) begin
            step();
            if (wen) begin nw++; last_wad = wad; end
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (wen || ren || primed) strobes++;
        end
        total++;
        if (nw != 2 || strobes != 0) begin
            bad++; $display("FAIL en_low writes=%0d strobes=%0d expected 2 0", nw, strobes);
        end
        en = 1'b1;
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ren) begin
                done = 1;
                total++;
                if (nw != 4) begin
                    bad++; $display("FAIL en_reprime writes=%0d expected=4", nw);
                end
                break;
            end
            if (wen) begin
                nw++;
                if (nw == 1) begin
                    total++;
                    if (wad !== last_wad + 9'd1) begin
                        bad++; $display("FAIL en_resume_wad actual=%0d expected=%0d", wad, last_wad + 9'd1);
                    end
                end
            end
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL en_timeout actual=no_read expected=read");
        end
    endtask

    task automatic test_reset_in_run();
        int nw = 0;
        bit done = 0;
        do_reset();
        div = 16'd0; delay = 9'd2; en = 1'b1;
        for (int i = 0; i < 20 && !primed; i++) step();
        step();
        step();
        rst_n = 1'b0;
        step();
        total++;
        if ({wen, wad, ren, rad, rd_valid, primed} !== 22'd0) begin
            bad++; $display("FAIL run_reset_outputs actual=%h expected=0",
                            {wen, wad, ren, rad, rd_valid, primed});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ren) begin
                done = 1;
                total++;
                if (nw != 2 || rad !== 9'd0 || wad !== 9'd2) begin
                    bad++; $display("FAIL run_reset_restart writes=%0d wad=%0d rad=%0d expected 2 2 0", nw, wad, rad);
                end
                break;
            end
            if (wen) begin
                if (nw == 0) begin
                    total++;
                    if (wad !== 9'd0) begin
                        bad++; $display("FAIL run_reset_wptr actual=%0d expected=0", wad);
                    end
                end
                nw++;
            end
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL run_reset_timeout actual=no_read expected=read");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_depth();
        test_wrap();
        test_delay_change();
        test_en_drop();
        test_reset_in_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
